pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Sequencer for pipeline stall, bubble, flush and memory-wait freeze in the 5-stage ARM core. Sits beside the forwarding unit between ID and EXE: detects RAW hazards that forwarding cannot cover, orders them against taken branches and multi-cycle SRAM accesses, and drives the hold/flush controls of the IF/ID, ID/EXE and later pipeline registers. Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before forced release (≥2)
- STALL_CNT_W, 16: width of stall_count
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- forwarding_en  in  1  1 = forwarding active; only load-use stalls
- id_valid  in  1  ID holds a real instruction
- src1, src2  in  4  ID source registers
- two_src  in  1  src2 is read by the ID instruction
- exe_dest  in  4, exe_wb_en  in  1, exe_mem_r_en  in  1  EXE-stage writeback info
- mem_dest  in  4, mem_wb_en  in  1  MEM-stage writeback info
- branch_taken  in  1  taken branch resolved in EXE
- mem_req  in  1  MEM stage issues SRAM access this cycle
- mem_ready  in  1  SRAM access completes this cycle
- freeze_if  out  1  hold PC and IF/ID
- bubble_id  out  1  load NOP into ID/EXE
- flush  out  1  clear IF/ID and ID/EXE
- freeze_all  out  1  hold every pipeline register
- mem_error  out  1  sticky MEM_WAIT timeout
- stall_count  out  STALL_CNT_W  saturating stall-cycle count

## Operation
- States: RUN (0), MEM_WAIT (1). Registered: state, wait_cnt (ceil log2 MEM_TIMEOUT bits), mem_error, stall_count.
- match1 = src1 == dest; match2 = two_src && src2 == dest.
- hazard (id_valid required):
  - forwarding_en=1: exe_wb_en && exe_mem_r_en && (match1||match2 vs exe_dest).
  - forwarding_en=0: (exe_wb_en && match vs exe_dest) || (mem_wb_en && match vs mem_dest).
- RUN, priority high→low:
  - mem_req && !mem_ready: freeze_all=1, others 0; next MEM_WAIT, wait_cnt←0.
  - branch_taken: flush=1; hazard ignored (ID instruction is discarded).
  - hazard: freeze_if=1, bubble_id=1.
  - else all controls 0.
- MEM_WAIT: freeze_if/bubble_id/flush=0 (branch_taken and hazard held frozen, re-evaluated after release).
  - mem_ready=1: freeze_all=0; next RUN.
  - mem_ready=0, wait_cnt==MEM_TIMEOUT-1: freeze_all=0, mem_error←1; next RUN.
  - else freeze_all=1, wait_cnt++.
- stall_count increments on each clock edge where freeze_all || bubble_id; saturates at all-ones.
- mem_error cleared only by rst.

## Timing
- rst high (async): state RUN, wait_cnt 0, mem_error 0, stall_count 0; freeze_if, bubble_id, flush, freeze_all forced 0 while rst high.
- freeze_if, bubble_id, flush, freeze_all combinational from state and inputs, same cycle; zero added latency.
- Load-use with forwarding: exactly one bubble; next cycle load is in MEM, hazard clears.
- Without forwarding: stall persists while producer is in EXE or MEM (up to two cycles).
- SRAM access of N wait cycles (mem_ready in Nth cycle after request, N≥1): freeze_all high N cycles, low in the mem_ready cycle.
- mem_ready=1 in request cycle: no freeze, state stays RUN.
- Timeout: freeze_all high for MEM_TIMEOUT cycles total (request cycle + MEM_TIMEOUT-1 in MEM_WAIT), low on cycle MEM_TIMEOUT+1; mem_error visible the following cycle.
- rst mid-MEM_WAIT: immediate return to RUN, freeze_all 0.

## Test plan
- Reset: rst=1 with mem_req=1, hazard inputs active -> all outputs 0, stall_count=0; release -> RUN behaviour next edge.
- forwarding_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3 for one cycle -> freeze_if=bubble_id=1 one cycle, stall_count=1; same with exe_mem_r_en=0 -> no stall.
- forwarding_en=0, two_src=1, src2=5, mem_dest=5, mem_wb_en=1 -> stall; two_src=0 -> no stall; branch_taken=1 with hazard -> flush=1, bubble_id=0.
- mem_req=1, mem_ready low 3 cycles then 1 -> freeze_all high 3 cycles, low on 4th, stall_count=3, state back to RUN; branch_taken held high throughout -> flush only after release.
- MEM_TIMEOUT=4, mem_ready stuck 0 -> freeze_all high 4 cycles, low on 5th, mem_error=1 from 6th until rst.
- STALL_CNT_W=3, 10 consecutive stall cycles -> stall_count saturates at 7.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: ID/EXE/MEM hazard and SRAM status in, pipeline hold/flush controls out.
interface pipeline_hazard_controller_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   forwarding_en;
  logic                   id_valid;
  logic [3:0]             src1;
  logic [3:0]             src2;
  logic                   two_src;
  logic [3:0]             exe_dest;
  logic                   exe_wb_en;
  logic                   exe_mem_r_en;
  logic [3:0]             mem_dest;
  logic                   mem_wb_en;
  logic                   branch_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   freeze_if;
  logic                   bubble_id;
  logic                   flush;
  logic                   freeze_all;
  logic                   mem_error;
  logic [STALL_CNT_W-1:0] stall_count;

  // Pipeline side: drives hazard/status, consumes controls.
  modport master (
    output forwarding_en, id_valid, src1, src2, two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    input  freeze_if, bubble_id, flush, freeze_all, mem_error, stall_count
  );

  // Controller side.
  modport slave (
    input  forwarding_en, id_valid, src1, src2, two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    output freeze_if, bubble_id, flush, freeze_all, mem_error, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/bubble/flush/memory-freeze sequencer for the 5-stage core. Controls are
// combinational from state and inputs; a saturating stall counter and a sticky
// memory-timeout flag are kept alongside.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_hazard_controller_if.slave   hz_if
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   mem_error_q, mem_error_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic exe_match, mem_match, hazard;
  logic freeze_if, bubble_id, flush, freeze_all;

  // RAW hazard detection that forwarding cannot cover.
  always_comb begin
    exe_match = (hz_if.src1 == hz_if.exe_dest) ||
                (hz_if.two_src && (hz_if.src2 == hz_if.exe_dest));
    mem_match = (hz_if.src1 == hz_if.mem_dest) ||
                (hz_if.two_src && (hz_if.src2 == hz_if.mem_dest));
    if (hz_if.forwarding_en)
      hazard = hz_if.id_valid && hz_if.exe_wb_en && hz_if.exe_mem_r_en && exe_match;
    else
      hazard = hz_if.id_valid &&
               ((hz_if.exe_wb_en && exe_match) || (hz_if.mem_wb_en && mem_match));
  end

  // Control decode and next-state: memory freeze beats branch flush beats hazard stall.
  always_comb begin
    freeze_if     = 1'b0;
    bubble_id     = 1'b0;
    flush         = 1'b0;
    freeze_all    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_error_d   = mem_error_q;
    case (state_q)
      RUN: begin
        if (hz_if.mem_req && !hz_if.mem_ready) begin
          freeze_all = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (hz_if.branch_taken) begin
          flush = 1'b1;
        end else if (hazard) begin
          freeze_if = 1'b1;
          bubble_id = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz_if.mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_error_d = 1'b1;
          state_d     = RUN;
        end else begin
          freeze_all = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    // Controls are held inactive for the whole reset pulse, not just after the edge.
    if (rst) begin
      freeze_if  = 1'b0;
      bubble_id  = 1'b0;
      flush      = 1'b0;
      freeze_all = 1'b0;
    end
    stall_count_d = stall_count_q;
    if ((freeze_all || bubble_id) && (stall_count_q != '1))
      stall_count_d = stall_count_q + 1'b1;
  end

  // State, wait counter, sticky error and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_error_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_error_q   <= mem_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz_if.freeze_if   = freeze_if;
  assign hz_if.bubble_id   = bubble_id;
  assign hz_if.flush       = flush;
  assign hz_if.freeze_all  = freeze_all;
  assign hz_if.mem_error   = mem_error_q;
  assign hz_if.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4, STALL_CNT_W=3.
module tb_pipeline_hazard_controller;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  pipeline_hazard_controller_if #(.STALL_CNT_W(CW)) hif ();

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(TMO),
    .STALL_CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    hif.forwarding_en = 1'b0;
    hif.id_valid      = 1'b0;
    hif.src1          = 4'd0;
    hif.src2          = 4'd0;
    hif.two_src       = 1'b0;
    hif.exe_dest      = 4'd0;
    hif.exe_wb_en     = 1'b0;
    hif.exe_mem_r_en  = 1'b0;
    hif.mem_dest      = 4'd0;
    hif.mem_wb_en     = 1'b0;
    hif.branch_taken  = 1'b0;
    hif.mem_req       = 1'b0;
    hif.mem_ready     = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are then driven
  // and combinational outputs checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic fi, input logic bi,
                         input logic fl, input logic fa);
    check({tag, ".freeze_if"},  hif.freeze_if,  fi);
    check({tag, ".bubble_id"},  hif.bubble_id,  bi);
    check({tag, ".flush"},      hif.flush,      fl);
    check({tag, ".freeze_all"}, hif.freeze_all, fa);
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset with aggressive inputs.
    idle();
    hif.mem_req = 1'b1; hif.id_valid = 1'b1; hif.src1 = 4'd3;
    hif.exe_dest = 4'd3; hif.exe_wb_en = 1'b1; hif.branch_taken = 1'b1;
    settle();
    chk_ctl("rst", 0, 0, 0, 0);
    check("rst.stall_count", hif.stall_count, 0);
    tick(); tick();
    chk_ctl("rst_hold", 0, 0, 0, 0);
    check("rst_hold.mem_error", hif.mem_error, 0);
    check("rst_hold.stall_count", hif.stall_count, 0);
    idle();
    rst = 1'b0;
    settle();
    chk_ctl("post_rst", 0, 0, 0, 0);

    // Load-use with forwarding: one bubble.
    tick();
    hif.forwarding_en = 1'b1; hif.id_valid = 1'b1; hif.src1 = 4'd3;
    hif.exe_dest = 4'd3; hif.exe_wb_en = 1'b1; hif.exe_mem_r_en = 1'b1;
    settle();
    chk_ctl("loaduse", 1, 1, 0, 0);
    tick();
    check("loaduse.stall_count", hif.stall_count, 1);
    hif.exe_wb_en = 1'b0; hif.exe_mem_r_en = 1'b0;
    hif.mem_dest = 4'd3; hif.mem_wb_en = 1'b1;
    settle();
    chk_ctl("loaduse_mem", 0, 0, 0, 0);
    tick();
    check("loaduse_mem.stall_count", hif.stall_count, 1);
    hif.mem_wb_en = 1'b0; hif.exe_wb_en = 1'b1; hif.exe_mem_r_en = 1'b0;
    settle();
    chk_ctl("fwd_alu", 0, 0, 0, 0);
    hif.exe_mem_r_en = 1'b1; hif.id_valid = 1'b0;
    settle();
    chk_ctl("no_id_valid", 0, 0, 0, 0);

    // No forwarding, src2 vs MEM stage.
    tick();
    idle();
    hif.id_valid = 1'b1; hif.two_src = 1'b1; hif.src1 = 4'd1; hif.src2 = 4'd5;
    hif.mem_dest = 4'd5; hif.mem_wb_en = 1'b1;
    settle();
    chk_ctl("nofwd_src2", 1, 1, 0, 0);
    tick();
    check("nofwd_src2.stall_count", hif.stall_count, 2);
    hif.two_src = 1'b0;
    settle();
    chk_ctl("nofwd_one_src", 0, 0, 0, 0);
    hif.two_src = 1'b1; hif.branch_taken = 1'b1;
    settle();
    chk_ctl("branch_hazard", 0, 0, 1, 0);
    tick();
    check("branch_hazard.stall_count", hif.stall_count, 2);
    idle();
    pulse_rst();
    check("async_rst.stall_count", hif.stall_count, 0);

    // Three-cycle SRAM wait with a branch held pending.
    tick();
    hif.mem_req = 1'b1; hif.branch_taken = 1'b1;
    settle();
    chk_ctl("memw_c1", 0, 0, 0, 1);
    tick();
    hif.mem_req = 1'b0;
    settle();
    chk_ctl("memw_c2", 0, 0, 0, 1);
    tick();
    settle();
    chk_ctl("memw_c3", 0, 0, 0, 1);
    tick();
    hif.mem_ready = 1'b1;
    settle();
    chk_ctl("memw_c4", 0, 0, 0, 0);
    tick();
    check("memw.stall_count", hif.stall_count, 3);
    hif.mem_ready = 1'b0;
    settle();
    chk_ctl("memw_release_flush", 0, 0, 1, 0);
    hif.branch_taken = 1'b0;

    // Zero-wait access stays in RUN.
    tick();
    hif.mem_req = 1'b1; hif.mem_ready = 1'b1;
    settle();
    chk_ctl("mem_zero_wait", 0, 0, 0, 0);
    tick();
    idle();
    settle();
    chk_ctl("mem_zero_wait_next", 0, 0, 0, 0);

    // Timeout: freeze for TMO cycles, error one cycle after release.
    pulse_rst();
    tick();
    hif.mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check($sformatf("tmo_c%0d.freeze_all", i), hif.freeze_all, 1);
      check($sformatf("tmo_c%0d.mem_error", i), hif.mem_error, 0);
      tick();
      hif.mem_req = 1'b0;
    end
    settle();
    check("tmo_c5.freeze_all", hif.freeze_all, 0);
    check("tmo_c5.mem_error", hif.mem_error, 0);
    tick();
    check("tmo.stall_count", hif.stall_count, 4);
    for (int i = 6; i <= 8; i++) begin
      settle();
      check($sformatf("tmo_c%0d.mem_error", i), hif.mem_error, 1);
      check($sformatf("tmo_c%0d.freeze_all", i), hif.freeze_all, 0);
      tick();
    end
    pulse_rst();
    check("tmo_rst.mem_error", hif.mem_error, 0);

    // Reset in the middle of MEM_WAIT.
    tick();
    hif.mem_req = 1'b1;
    tick();
    hif.mem_req = 1'b0;
    settle();
    check("midrst_wait.freeze_all", hif.freeze_all, 1);
    rst = 1'b1;
    settle();
    check("midrst_high.freeze_all", hif.freeze_all, 0);
    rst = 1'b0;
    settle();
    check("midrst_run.freeze_all", hif.freeze_all, 0);
    check("midrst.stall_count", hif.stall_count, 0);

    // Ten consecutive stall cycles saturate the 3-bit counter.
    tick();
    hif.id_valid = 1'b1; hif.src1 = 4'd7; hif.exe_dest = 4'd7; hif.exe_wb_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("sat_%0d.stall_count", i), hif.stall_count, (i < 7) ? i : 7);
    end
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
